// File: rtl/gigatron_video_capture_if.sv
// Pixel record stream from the video capture block to a framebuffer writer.
// The master drives valid/x/y/color; the slave drives ready.
interface gigatron_video_capture_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_x;
  logic [8:0] pix_y;
  logic [5:0] pix_color;

  modport master (output pix_valid, pix_x, pix_y, pix_color, input pix_ready);
  modport slave  (input pix_valid, pix_x, pix_y, pix_color, output pix_ready);
endinterface

// File: rtl/gigatron_video_capture.sv
// Gigatron video port receiver: recovers line/frame timing from the OUT register stream and
// emits (x, y, colour) records through a 2-entry buffer. Optional: VIDEO_CAPTURE_SYNC_CHECK_EN.
module gigatron_video_capture #(
  parameter int H_BACK_PORCH = 36,
  parameter int H_ACTIVE     = 160,
  parameter int V_BACK_PORCH = 35,
  parameter int V_ACTIVE     = 480,
  parameter int H_TOTAL      = 200
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic [7:0]                       i_out,
  gigatron_video_capture_if.master         pix,
  output logic                             o_frame_start,
  output logic                             o_overflow,
  output logic                             o_sync_err
);

  localparam logic [7:0] HBP  = 8'(H_BACK_PORCH);
  localparam logic [7:0] HEND = 8'(H_BACK_PORCH + H_ACTIVE);
  localparam logic [9:0] VBP  = 10'(V_BACK_PORCH);
  localparam logic [9:0] VEND = 10'(V_BACK_PORCH + V_ACTIVE);
  localparam logic [8:0] VBP9 = 9'(V_BACK_PORCH);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [8:0] y;
    logic [5:0] color;
  } rec_t;

  state_t     state_r, state_next;
  logic [7:0] in_q_r;
  logic [1:0] sync_prev_r;
  logic [7:0] hcnt_r, hcnt_s;
  logic [9:0] line_r, line_s;
  logic       hs_fall_s, vs_fall_s, visible_s;
  rec_t       rec_s;
  rec_t       fifo_r [2];
  logic       wr_ptr_r, rd_ptr_r;
  logic [1:0] count_r;
  logic       full_s, pop_s, push_ok_s;

  // Next-state logic: lock on the first vsync falling edge, stay locked until reset.
  always_comb begin
    state_next = state_r;
    case (state_r)
      SEARCH: begin
        if (vs_fall_s) state_next = LOCKED;
        else           state_next = SEARCH;
      end
      LOCKED:  state_next = LOCKED;
      default: state_next = SEARCH;
    endcase
  end

  // Counters for the current sample in in_q; hcnt/line registers hold the previous sample's values.
  always_comb begin
    hs_fall_s = sync_prev_r[0] & ~in_q_r[6];
    vs_fall_s = sync_prev_r[1] & ~in_q_r[7];
    if (hs_fall_s)               hcnt_s = 8'd0;
    else if (hcnt_r == 8'hFF)    hcnt_s = 8'hFF;
    else                         hcnt_s = hcnt_r + 8'd1;
    if (vs_fall_s)               line_s = 10'd0;
    else if (!hs_fall_s)         line_s = line_r;
    else if (line_r == 10'h3FF)  line_s = 10'h3FF;
    else                         line_s = line_r + 10'd1;
    visible_s = (state_next == LOCKED) && (line_s >= VBP) && (line_s < VEND) &&
                (hcnt_s >= HBP) && (hcnt_s < HEND);
    rec_s.x     = hcnt_s - HBP;
    rec_s.y     = line_s[8:0] - VBP9;
    rec_s.color = in_q_r[5:0];
  end

  // Input sampling, timing counters, FSM state and frame-start pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r       <= SEARCH;
      in_q_r        <= 8'hC0;
      sync_prev_r   <= 2'b11;
      hcnt_r        <= 8'd0;
      line_r        <= 10'd0;
      o_frame_start <= 1'b0;
    end else begin
      state_r       <= state_next;
      in_q_r        <= i_out;
      sync_prev_r   <= in_q_r[7:6];
      hcnt_r        <= hcnt_s;
      line_r        <= line_s;
      o_frame_start <= vs_fall_s;
    end
  end

  assign full_s    = (count_r == 2'd2);
  assign pop_s     = (count_r != 2'd0) & pix.pix_ready;
  // A full buffer still accepts a push when the head leaves in the same clock.
  assign push_ok_s = visible_s & (~full_s | pop_s);

  // Two-entry record buffer with sticky drop flag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      fifo_r[0]  <= '0;
      fifo_r[1]  <= '0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
      o_overflow <= 1'b0;
    end else begin
      if (push_ok_s) begin
        fifo_r[wr_ptr_r] <= rec_s;
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= ~rd_ptr_r;
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
      if (visible_s && full_s && !pop_s) o_overflow <= 1'b1;
    end
  end

  assign pix.pix_valid = (count_r != 2'd0);
  assign {pix.pix_x, pix.pix_y, pix.pix_color} = fifo_r[rd_ptr_r];

`ifdef VIDEO_CAPTURE_SYNC_CHECK_EN
  localparam logic [8:0] HTOT = 9'(H_TOTAL);
  logic armed_r;
  logic len_bad_s;

  // Line length is the previous sample's hcnt plus one; a saturated count can never match.
  assign len_bad_s = (({1'b0, hcnt_r} + 9'd1) != HTOT);

  // Sticky line-length check, skipping the first hsync edge after lock.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      armed_r    <= 1'b0;
      o_sync_err <= 1'b0;
    end else if (hs_fall_s && (state_next == LOCKED)) begin
      armed_r <= 1'b1;
      if (armed_r && len_bad_s) o_sync_err <= 1'b1;
    end
  end
`else
  assign o_sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_gigatron_video_capture.sv
// Scoreboard bench for gigatron_video_capture: a reference timing model pushes expected records
// as stimulus is driven; a negedge monitor pops and compares on every accepted record.
module tb_gigatron_video_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dout;
  logic       frame_start, overflow, sync_err;

  gigatron_video_capture_if pix ();

  gigatron_video_capture dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_out        (dout),
    .pix          (pix),
    .o_frame_start(frame_start),
    .o_overflow   (overflow),
    .o_sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [22:0] exp_q [$];
  logic [22:0] first_rec, last_rec, mon_got, mon_exp;
  int          test_recs = 0;
  int          fs_seen = 0;
  int          exp_fs = 0;

  logic [1:0]  m_prev;
  int          m_hcnt, m_line;
  bit          m_locked;
  bit          suppress = 1'b0;
  int          ready_at = -1;

  // Reference model of the line/frame timing, then apply the sample for one clock.
  task automatic drive(input logic [7:0] v);
    bit hf, vf;
    int x, y;
    hf = m_prev[0] && !v[6];
    vf = m_prev[1] && !v[7];
    if (hf) m_hcnt = 0;
    else if (m_hcnt < 255) m_hcnt++;
    if (vf) m_line = 0;
    else if (hf && m_line < 1023) m_line++;
    if (vf) begin
      m_locked = 1'b1;
      exp_fs++;
    end
    x = m_hcnt - 36;
    y = m_line - 35;
    if (m_locked && m_line >= 35 && m_line < 515 && m_hcnt >= 36 && m_hcnt < 196 &&
        !(suppress && x >= 2))
      exp_q.push_back({x[7:0], y[8:0], v[5:0]});
    m_prev = v[7:6];
    dout = v;
    @(posedge clk); #1;
  endtask

  // One line: hsync low for hs_low clocks from the start; col < 0 means colour = position in line.
  task automatic drive_line(input int len, input int hs_low, input bit vs_low, input int col);
    for (int c = 0; c < len; c++) begin
      logic [5:0] cc;
      if (c == ready_at) pix.pix_ready = 1'b1;
      cc = (col < 0) ? c[5:0] : col[5:0];
      drive({~vs_low, (c < hs_low) ? 1'b0 : 1'b1, cc});
    end
  endtask

  // Vsync frame start followed by 2-clock lines up to (not including) line target.
  task automatic goto_line(input int target);
    for (int l = 0; l < target; l++) drive_line(2, 1, (l < 2), -1);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    dout = 8'hC0;
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst       = 1'b0;
    m_prev    = 2'b11;
    m_hcnt    = 0;
    m_line    = 0;
    m_locked  = 1'b0;
    test_recs = 0;
  endtask

  // Monitor: compare every accepted record against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_start) fs_seen++;
      if (pix.pix_valid && pix.pix_ready) begin
        mon_got = {pix.pix_x, pix.pix_y, pix.pix_color};
        check_val("rec_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check_val("rec", 32'(mon_got), 32'(mon_exp));
        end
        if (test_recs == 0) first_rec = mon_got;
        last_rec = mon_got;
        test_recs++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dout = 8'hC0;
    pix.pix_ready = 1'b1;
    do_reset();

    // Reset mid-line with two records buffered
    goto_line(35);
    pix.pix_ready = 1'b0;
    drive_line(39, 24, 1'b0, -1);
    check_val("t1_buffered_valid", 32'(pix.pix_valid), 32'd1);
    check_val("t1_head_x", 32'(pix.pix_x), 32'd0);
    do_reset();
    check_val("t1_valid", 32'(pix.pix_valid), 32'd0);
    check_val("t1_overflow", 32'(overflow), 32'd0);
    check_val("t1_frame_start", 32'(frame_start), 32'd0);
    check_val("t1_sync_err", 32'(sync_err), 32'd0);

    // Nominal lines without vsync: never locks
    pix.pix_ready = 1'b1;
    repeat (5) drive_line(200, 24, 1'b0, 63);
    check_val("t2_recs", 32'(test_recs), 32'd0);
    check_val("t2_valid", 32'(pix.pix_valid), 32'd0);

    // Frame: full-length lines only at first and last visible line
    test_recs = 0;
    for (int l = 0; l < 521; l++) begin
      if (l == 35 || l == 514) drive_line(200, 24, (l < 2), -1);
      else                     drive_line(2, 1, (l < 2), -1);
    end
    drive_line(2, 1, 1'b1, -1);
    drive_line(2, 1, 1'b0, -1);
    check_val("t3_count", 32'(test_recs), 32'd320);
    check_val("t3_first", 32'(first_rec), 32'({8'd0, 9'd0, 6'h24}));
    check_val("t3_last", 32'(last_rec), 32'({8'd159, 9'd479, 6'h03}));
    check_val("t3_pending", 32'(exp_q.size()), 32'd0);
    check_val("t3_frame_starts", 32'(fs_seen), 32'(exp_fs));

    // Stall from line start: x=0,1 held, rest dropped
    do_reset();
    goto_line(35);
    pix.pix_ready = 1'b0;
    suppress = 1'b1;
    drive_line(200, 24, 1'b0, -1);
    check_val("t4_hold_valid", 32'(pix.pix_valid), 32'd1);
    check_val("t4_hold_x", 32'(pix.pix_x), 32'd0);
    check_val("t4_overflow", 32'(overflow), 32'd1);
    pix.pix_ready = 1'b1;
    suppress = 1'b0;
    drive_line(2, 1, 1'b0, -1);
    drive_line(2, 1, 1'b0, -1);
    check_val("t4_drained", 32'(test_recs), 32'd2);
    check_val("t4_overflow_sticky", 32'(overflow), 32'd1);
    check_val("t4_pending", 32'(exp_q.size()), 32'd0);

    // Full buffer with simultaneous push/pop: nothing dropped
    do_reset();
    goto_line(35);
    pix.pix_ready = 1'b0;
    ready_at = 39;
    drive_line(200, 24, 1'b0, -1);
    ready_at = -1;
    drive_line(2, 1, 1'b0, -1);
    drive_line(2, 1, 1'b0, -1);
    check_val("t5_count", 32'(test_recs), 32'd160);
    check_val("t5_overflow", 32'(overflow), 32'd0);
    check_val("t5_pending", 32'(exp_q.size()), 32'd0);

    // Short line after lock
    do_reset();
    pix.pix_ready = 1'b1;
    drive_line(200, 24, 1'b1, -1);
    drive_line(200, 24, 1'b1, -1);
    drive_line(199, 24, 1'b0, -1);
    check_val("t6_sync_ok", 32'(sync_err), 32'd0);
    drive_line(5, 24, 1'b0, -1);
`ifdef VIDEO_CAPTURE_SYNC_CHECK_EN
    check_val("t6_sync_err", 32'(sync_err), 32'd1);
`else
    check_val("t6_sync_err", 32'(sync_err), 32'd0);
`endif

    // Reset inside visible line 100: silent until next vsync
    do_reset();
    goto_line(135);
    drive_line(100, 24, 1'b0, -1);
    do_reset();
    drive_line(100, 24, 1'b0, -1);
    repeat (3) drive_line(200, 24, 1'b0, -1);
    check_val("t7_no_recs", 32'(test_recs), 32'd0);
    goto_line(35);
    drive_line(200, 24, 1'b0, -1);
    drive_line(2, 1, 1'b0, -1);
    check_val("t7_resume", 32'(test_recs), 32'd160);

    check_val("frame_starts", 32'(fs_seen), 32'(exp_fs));
    check_val("final_pending", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
